// File: rtl/ysyx_23060203_pkg.sv
// Shared definitions for the ysyx_23060203 core: IFU state encoding, AXI response codes, reset PC.
package ysyx_23060203_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        S_ADDR = 2'b00,
        S_DATA = 2'b01,
        S_OUT  = 2'b10,
        S_WAIT = 2'b11
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060203_ifu.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, handed to decode over valid/ready,
// then waits for the commit side to return the next PC.
// Optional feature macro: YSYX_23060203_IFU_PERF_EN adds fetch/stall performance counters.
module ysyx_23060203_ifu
    import ysyx_23060203_pkg::*;
#(
    parameter int unsigned          XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0]      RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rstn,
    output logic [XLEN-1:0] mem_araddr,
    output logic            mem_arvalid,
    input  logic            mem_arready,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      mem_rresp,
    input  logic            mem_rvalid,
    output logic            mem_rready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_fault,
    output logic            out_valid,
    input  logic            out_ready,
`ifdef YSYX_23060203_IFU_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt,
`endif
    input  logic [XLEN-1:0] npc,
    input  logic            npc_valid,
    output logic            npc_ready
);

    ifu_state_e      state;
    ifu_state_e      state_n;
    logic [XLEN-1:0] pc;

    logic ar_fire;
    logic r_fire;
    logic out_fire;
    logic npc_fire;

    // Handshakes use the registered flags, so nothing fires in the first cycle after reset.
    assign ar_fire  = mem_arvalid && mem_arready;
    assign r_fire   = mem_rvalid  && mem_rready;
    assign out_fire = out_valid   && out_ready;
    assign npc_fire = npc_valid   && npc_ready;

    assign mem_araddr = pc;

    // Next-state logic: advance only on the handshake owned by the current state.
    always_comb begin
        state_n = state;
        case (state)
            S_ADDR:  if (ar_fire)  state_n = S_DATA;
            S_DATA:  if (r_fire)   state_n = S_OUT;
            S_OUT:   if (out_fire) state_n = S_WAIT;
            S_WAIT:  if (npc_fire) state_n = S_ADDR;
            default: state_n = S_ADDR;
        endcase
    end

    // State, PC, captured instruction and per-state handshake flags (decoded from next state).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= S_ADDR;
            pc          <= RESET_PC;
            out_inst    <= '0;
            out_pc      <= '0;
            out_fault   <= 1'b0;
            mem_arvalid <= 1'b0;
            mem_rready  <= 1'b0;
            out_valid   <= 1'b0;
            npc_ready   <= 1'b0;
        end else begin
            state       <= state_n;
            mem_arvalid <= (state_n == S_ADDR);
            mem_rready  <= (state_n == S_DATA);
            out_valid   <= (state_n == S_OUT);
            npc_ready   <= (state_n == S_WAIT);
            if (r_fire) begin
                out_inst  <= mem_rdata;
                out_pc    <= pc;
                out_fault <= (mem_rresp != RESP_OKAY);
            end
            if (npc_fire) begin
                pc <= npc;
            end
        end
    end

`ifdef YSYX_23060203_IFU_PERF_EN
    logic stall;

    assign stall = ((state == S_ADDR) && !ar_fire) || ((state == S_DATA) && !r_fire);

    // Wrapping counters: delivered instructions and cycles spent waiting on memory.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_fetch_cnt <= 32'd0;
            perf_stall_cnt <= 32'd0;
        end else begin
            if (out_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060203_ifu.sv
// Scoreboard bench for ysyx_23060203_ifu: the driver plays memory, decode and commit and
// queues expected AR addresses and delivered instructions; negedge monitors pop and compare.
module tb_ysyx_23060203_ifu;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [31:0] mem_araddr;
    logic        mem_arvalid;
    logic        mem_arready;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_rresp;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] npc;
    logic        npc_valid;
    logic        npc_ready;
`ifdef YSYX_23060203_IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] ar_q[$];
    exp_t        out_q[$];

    ysyx_23060203_ifu dut (
        .clk         (clk),
        .rstn        (rstn),
        .mem_araddr  (mem_araddr),
        .mem_arvalid (mem_arvalid),
        .mem_arready (mem_arready),
        .mem_rdata   (mem_rdata),
        .mem_rresp   (mem_rresp),
        .mem_rvalid  (mem_rvalid),
        .mem_rready  (mem_rready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_fault   (out_fault),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef YSYX_23060203_IFU_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .npc         (npc),
        .npc_valid   (npc_valid),
        .npc_ready   (npc_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitors: compare every AR handshake and every decode handshake against the queues.
    always @(negedge clk) begin
        chk1("onehot_handshake", ($countones({mem_arvalid, mem_rready, out_valid, npc_ready}) > 1), 1'b0);
        if (mem_arvalid && mem_arready) begin
            chk1("ar_expected", (ar_q.size() != 0), 1'b1);
            if (ar_q.size() != 0) chk("ar_addr", mem_araddr, ar_q.pop_front());
        end
        if (out_valid && out_ready) begin
            chk1("out_expected", (out_q.size() != 0), 1'b1);
            if (out_q.size() != 0) begin
                exp_t e;
                e = out_q.pop_front();
                chk("out_inst", out_inst, e.inst);
                chk("out_pc", out_pc, e.pc);
                chk1("out_fault", out_fault, e.fault);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ar();
        int n = 0;
        while (!mem_arvalid && n < 40) begin
            step();
            n++;
        end
        chk1("ar_wait_timeout", mem_arvalid, 1'b1);
    endtask

    // One full fetch loop with configurable memory / decode stalls and an optional stray npc pulse.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp,
                         input int ar_dly, input int r_dly, input int out_dly,
                         input logic [31:0] nxt, input bit pulse);
        exp_t e;
        e.inst  = data;
        e.pc    = addr;
        e.fault = (resp != 2'b00);
        ar_q.push_back(addr);
        out_q.push_back(e);
        wait_ar();
        for (int i = 0; i < ar_dly; i++) begin
            chk("araddr_stable", mem_araddr, addr);
            chk1("arvalid_held", mem_arvalid, 1'b1);
            step();
        end
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        chk1("rready", mem_rready, 1'b1);
        chk1("no_dup_ar", mem_arvalid, 1'b0);
        if (pulse) begin
            npc       = 32'h1234_5678;
            npc_valid = 1'b1;
            chk1("npc_ready_in_data", npc_ready, 1'b0);
            step();
            npc_valid = 1'b0;
            chk1("rready_after_stray_npc", mem_rready, 1'b1);
        end
        for (int i = 0; i < r_dly; i++) begin
            chk1("no_dup_ar_wait", mem_arvalid, 1'b0);
            chk1("out_valid_early", out_valid, 1'b0);
            step();
        end
        mem_rvalid = 1'b1;
        mem_rdata  = data;
        mem_rresp  = resp;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_rresp  = 2'b00;
        chk1("out_valid_latency", out_valid, 1'b1);
        for (int i = 0; i < out_dly; i++) begin
            chk("hold_inst", out_inst, data);
            chk("hold_pc", out_pc, addr);
            chk1("hold_valid", out_valid, 1'b1);
            chk1("npc_ready_early", npc_ready, 1'b0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk1("npc_ready", npc_ready, 1'b1);
        chk1("out_valid_drop", out_valid, 1'b0);
        npc       = nxt;
        npc_valid = 1'b1;
        step();
        npc_valid = 1'b0;
        chk1("arvalid_after_npc", mem_arvalid, 1'b1);
        chk("next_araddr", mem_araddr, nxt);
    endtask

    initial begin
        rstn        = 1'b0;
        mem_arready = 1'b0;
        mem_rdata   = 32'h0;
        mem_rresp   = 2'b00;
        mem_rvalid  = 1'b0;
        out_ready   = 1'b0;
        npc         = 32'h0;
        npc_valid   = 1'b0;
        repeat (3) step();

        chk1("rst_arvalid", mem_arvalid, 1'b0);
        chk1("rst_rready", mem_rready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_npc_ready", npc_ready, 1'b0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk1("rst_out_fault", out_fault, 1'b0);
        chk("rst_araddr", mem_araddr, 32'h8000_0000);

        rstn = 1'b1;
        // zero-wait memory, decode always ready
        fetch(32'h8000_0000, 32'h0000_0413, 2'b00, 0, 0, 0, 32'h8000_0004, 1'b0);
        // slow address and data channels
        fetch(32'h8000_0004, 32'h0010_0093, 2'b00, 3, 5, 0, 32'h8000_0008, 1'b0);
        // decode back-pressure
        fetch(32'h8000_0008, 32'h0020_0113, 2'b00, 0, 0, 4, 32'h8000_000C, 1'b0);
        // faulting response plus a stray npc pulse while waiting for data
        fetch(32'h8000_000C, 32'hDEAD_BEEF, 2'b10, 0, 1, 0, 32'h8000_0010, 1'b1);
        // next fetch is clean again
        fetch(32'h8000_0010, 32'h0000_0013, 2'b00, 1, 0, 1, 32'h8000_0014, 1'b0);

        // reset in S_DATA, with rvalid arriving during and just after reset
        ar_q.push_back(32'h8000_0014);
        wait_ar();
        mem_arready = 1'b1;
        step();
        mem_arready = 1'b0;
        chk1("pre_rst_rready", mem_rready, 1'b1);
        rstn       = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_BAD0;
        step();
        chk1("midrst_arvalid", mem_arvalid, 1'b0);
        chk1("midrst_rready", mem_rready, 1'b0);
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_npc_ready", npc_ready, 1'b0);
`ifdef YSYX_23060203_IFU_PERF_EN
        chk("perf_fetch_rst", perf_fetch_cnt, 32'h0);
        chk("perf_stall_rst", perf_stall_cnt, 32'h0);
`endif
        step();
        rstn = 1'b1;
        step();
        chk1("late_rvalid_rready", mem_rready, 1'b0);
        chk1("late_rvalid_out_valid", out_valid, 1'b0);
        chk1("post_rst_arvalid", mem_arvalid, 1'b1);
        chk("post_rst_araddr", mem_araddr, 32'h8000_0000);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        fetch(32'h8000_0000, 32'h0000_0513, 2'b00, 0, 0, 0, 32'h8000_0004, 1'b0);
`ifdef YSYX_23060203_IFU_PERF_EN
        chk("perf_fetch_end", perf_fetch_cnt, 32'h1);
`endif

        step();
        chk("ar_q_drained", 32'(ar_q.size()), 32'h0);
        chk("out_q_drained", 32'(out_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
